// File: rtl/freq_gate_gen.sv
// Avalon-MM programmable measurement gate generator for the frequency meter.
// Drives freq_en for GATE_LEN cycles, optionally repeating after GAP_LEN idle cycles.
module freq_gate_gen #(
  parameter int CNT_W    = 32,
  parameter int GATE_RST = 50_000_000,
  parameter int GAP_RST  = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        freq_en,
  output logic        gate_start,
  output logic        gate_end
);

  typedef enum logic [1:0] {IDLE, GATE, GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] gate_len_q, gate_len_d;
  logic [CNT_W-1:0] gap_len_q, gap_len_d;
  logic [15:0]      gate_cnt_q, gate_cnt_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             cont_q, cont_d;
  logic             done_q, done_d;
  logic             freq_en_q, freq_en_d;
  logic             gate_start_q, gate_start_d;
  logic             gate_end_q, gate_end_d;

  logic [CNT_W-1:0] gate_load, gap_load;
  logic             wr_ctrl, stop, start, expire;

  // A programmed length of zero behaves as a single cycle.
  assign gate_load = (gate_len_q == '0) ? CNT_W'(1) : gate_len_q;
  assign gap_load  = (gap_len_q == '0) ? CNT_W'(1) : gap_len_q;
  assign wr_ctrl   = write && (address == 2'd0);
  assign stop      = wr_ctrl && writedata[2];
  assign start     = wr_ctrl && writedata[0] && !writedata[2];
  assign expire    = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gate_len_d   = gate_len_q;
    gap_len_d    = gap_len_q;
    gate_cnt_d   = gate_cnt_q;
    cont_d       = cont_q;
    done_d       = done_q;
    freq_en_d    = freq_en_q;
    gate_start_d = 1'b0;
    gate_end_d   = 1'b0;

    if (write && address == 2'd1) gate_len_d = writedata[CNT_W-1:0];
    if (write && address == 2'd2) gap_len_d = writedata[CNT_W-1:0];
    if (write && address == 2'd3 && writedata[2]) done_d = 1'b0;

    // STOP overrides everything; done assignments below come later so a set beats a clear.
    if (stop) begin
      state_d    = IDLE;
      freq_en_d  = 1'b0;
      gate_end_d = freq_en_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cont_d       = writedata[1];
            gate_cnt_d   = '0;
            done_d       = 1'b0;
            state_d      = GATE;
            cnt_d        = gate_load;
            freq_en_d    = 1'b1;
            gate_start_d = 1'b1;
          end
        end
        GATE: begin
          if (expire) begin
            gate_cnt_d = gate_cnt_q + 16'd1;
            freq_en_d  = 1'b0;
            gate_end_d = 1'b1;
            if (cont_q) begin
              state_d = GAP;
              cnt_d   = gap_load;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        GAP: begin
          if (expire) begin
            state_d      = GATE;
            cnt_d        = gate_load;
            freq_en_d    = 1'b1;
            gate_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0: readdata_d[1] = cont_q;
      2'd1: readdata_d[CNT_W-1:0] = gate_len_q;
      2'd2: readdata_d[CNT_W-1:0] = gap_len_q;
      default: readdata_d = {gate_cnt_q, 13'd0, done_q, freq_en_q, (state_q != IDLE)};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gate_len_q   <= CNT_W'(GATE_RST);
      gap_len_q    <= CNT_W'(GAP_RST);
      gate_cnt_q   <= '0;
      readdata_q   <= '0;
      cont_q       <= 1'b0;
      done_q       <= 1'b0;
      freq_en_q    <= 1'b0;
      gate_start_q <= 1'b0;
      gate_end_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gate_len_q   <= gate_len_d;
      gap_len_q    <= gap_len_d;
      gate_cnt_q   <= gate_cnt_d;
      readdata_q   <= readdata_d;
      cont_q       <= cont_d;
      done_q       <= done_d;
      freq_en_q    <= freq_en_d;
      gate_start_q <= gate_start_d;
      gate_end_q   <= gate_end_d;
    end
  end

  assign readdata   = readdata_q;
  assign freq_en    = freq_en_q;
  assign gate_start = gate_start_q;
  assign gate_end   = gate_end_q;

endmodule

// File: doc/freq_gate_gen.md
# freq_gate_gen

Measurement-gate generator for the frequency meter: the driving end of the `freq_en` line that the Nios polls through its read-only input PIO. The block is an Avalon-MM slave on the Nios display system bus. Software programs a gate length and an inter-gate gap, then starts single or continuous gates. The block drives `freq_en` high for exactly the programmed number of `clk` cycles per gate and reports progress back through a status register.

## Interface
- `CNT_W`, default 32: width of the gate and gap counters and length registers (1..32).
- `GATE_RST`, default 50_000_000: reset value of GATE_LEN (1 s at 50 MHz).
- `GAP_RST`, default 1000: reset value of GAP_LEN.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  2  register select.
- `write`  in  1  write strobe, single cycle, no wait states.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `freq_en`  out  1  measurement gate, registered.
- `gate_start`  out  1  one-cycle pulse on the first cycle `freq_en` is high.
- `gate_end`  out  1  one-cycle pulse on the first cycle `freq_en` is low after a gate.

## Operation
- Registers:
  - 0 CTRL (write): bit0 START, bit1 CONT, bit2 STOP. Reads return {30'b0, cont_mode, 1'b0}.
  - 1 GATE_LEN: R/W, `CNT_W` bits, zero-extended.
  - 2 GAP_LEN: R/W, `CNT_W` bits, zero-extended.
  - 3 STATUS: bit0 busy, bit1 `freq_en`, bit2 done (sticky), bits[31:16] gate_cnt. Writing 1 to bit2 clears done.
- A length value of 0 is treated as 1 for both GATE_LEN and GAP_LEN.
- States and transitions:
  - IDLE: go to GATE on START.
  - GATE: go to GAP when the count expires and cont_mode=1; go to IDLE (set done) when it expires and cont_mode=0.
  - GAP: go to GATE when the count expires.
  - Any state: go to IDLE on STOP (done unchanged).
- Shadowing: the down-counter loads GATE_LEN on every GATE entry and GAP_LEN on every GAP entry. Register writes mid-run take effect at the next entry.
- START:
  - In IDLE: latches CONT into cont_mode, clears gate_cnt and done.
  - In GATE or GAP: ignored entirely; CONT does not change.
- STOP and START in the same write: STOP wins, state becomes IDLE.
- gate_cnt increments (16-bit, wraps at 0xFFFF to 0) each time a GATE state completes normally. An aborted gate does not count.
- done set and done clear in the same cycle: set wins.
- busy = (state != IDLE).

## Timing
- Reset values:
  - `freq_en`, `gate_start`, `gate_end` = 0.
  - `readdata` = 0.
  - state = IDLE; done, cont_mode, gate_cnt = 0.
  - GATE_LEN = `GATE_RST`; GAP_LEN = `GAP_RST`.
- Reset mid-gate: `freq_en` is 0 on the cycle after `reset` is sampled high. No `gate_end` pulse is generated.
- START written at edge T: `freq_en`=1 and `gate_start`=1 from edge T+1. `freq_en` stays high for exactly max(GATE_LEN,1) cycles.
- Gate ending normally:
  - `freq_en` falls and `gate_end` pulses on the same edge.
  - done and gate_cnt update on that edge.
  - busy falls on that edge in single mode.
- Continuous mode: `freq_en` is low for exactly max(GAP_LEN,1) cycles, then rises again with `gate_start`.
- STOP at edge T: `freq_en`=0 from T+1. `gate_end` pulses at T+1 only if `freq_en` was 1.
- `readdata` is updated every cycle from `address` (no read strobe), giving one-cycle read latency. The value reflects register state before any same-cycle write.

## Test plan
- Reset, then read all four addresses -> 0, 0x02FAF080, 0x3E8, 0. `freq_en`=0.
- GATE_LEN=5, START (single) -> `freq_en` high exactly 5 cycles starting the cycle after the write. One `gate_start` and one `gate_end` pulse. STATUS then reads 0x00010004.
- GATE_LEN=3, GAP_LEN=2, START|CONT for 20 cycles -> `freq_en` pattern 111 00 repeating. gate_cnt increments once per gate. STOP mid-gate -> `freq_en` 0 next cycle and gate_cnt not incremented.
- GATE_LEN=0 and GAP_LEN=0 in continuous mode -> alternating 1,0 each cycle. A START|STOP write from IDLE -> state stays IDLE, `freq_en` stays 0.
- Write GATE_LEN=10 during a 4-cycle gate -> current gate lasts 4 cycles, next gate lasts 10. A second START while busy -> no effect on timing or cont_mode.
- Done set coinciding with a STATUS write of 0x4 -> done reads 1. Reset asserted mid-gate -> `freq_en` 0 next cycle and all registers at reset values.
